// File: rtl/canvas_scanout_if.sv
// ---------------------------------------------------------------------------
// canvas_scanout_if
//
// Pixel stream bundle between the canvas raster reader and the
// compositor/VGA side. One beat carries a colour, its canvas coordinates and
// the frame/line markers. Transfer happens on out_valid && out_ready.
//
// Signals:
//   out_valid  source -> sink  beat valid
//   out_ready  sink -> source  sink accepts the beat
//   out_color  source -> sink  pixel colour
//   out_x      source -> sink  pixel column
//   out_y      source -> sink  pixel row
//   out_sof    source -> sink  beat is pixel (0,0)
//   out_eol    source -> sink  beat is the last column of a row
//
// Modports:
//   master  the pixel source (canvas_scanout)
//   slave   the pixel sink
// ---------------------------------------------------------------------------
interface canvas_scanout_if #(
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 480,
  parameter int COLOR_WIDTH = 12
);

  localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  logic                   out_valid;
  logic                   out_ready;
  logic [COLOR_WIDTH-1:0] out_color;
  logic [XW-1:0]          out_x;
  logic [YW-1:0]          out_y;
  logic                   out_sof;
  logic                   out_eol;

  modport master (
    output out_valid,
    output out_color,
    output out_x,
    output out_y,
    output out_sof,
    output out_eol,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_color,
    input  out_x,
    input  out_y,
    input  out_sof,
    input  out_eol,
    output out_ready
  );

endinterface

// File: rtl/canvas_scanout.sv
// ---------------------------------------------------------------------------
// canvas_scanout
//
// Raster reader for the drawing canvas frame store. A start request walks
// every canvas address in row-major order over the canvas read port (one
// cycle registered read latency) and returns each pixel as a valid/ready
// stream tagged with coordinates and frame/line markers. A 2-entry skid FIFO
// absorbs downstream backpressure; reads are only issued while the FIFO plus
// the read in flight have room, so nothing is lost, duplicated or overrun.
//
// Parameters:
//   WIDTH, HEIGHT  canvas size in pixels
//   COLOR_WIDTH    colour width shared with the rest of the canvas system
//   COLOR_NONE     blank colour shown on the stream while no beat is valid
//
// Ports:
//   clk           clock
//   reset         synchronous, active-high reset
//   start_i       request one full-frame scan (only looked at while idle)
//   busy_o        a frame is being scanned or drained
//   rd_x_o        canvas read column
//   rd_y_o        canvas read row
//   rd_en_o       read issued at the coming edge
//   rd_color_i    canvas data for the address issued at the previous edge
//   out_if        pixel stream (master side)
//   frame_done_o  one-cycle pulse once the last beat of the frame is taken
// ---------------------------------------------------------------------------
module canvas_scanout #(
  parameter int                     WIDTH       = 640,
  parameter int                     HEIGHT      = 480,
  parameter int                     COLOR_WIDTH = 12,
  parameter logic [COLOR_WIDTH-1:0] COLOR_NONE  = '1,
  localparam int                    XW          = (WIDTH  > 1) ? $clog2(WIDTH)  : 1,
  localparam int                    YW          = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_i,
  output logic                   busy_o,
  output logic [XW-1:0]          rd_x_o,
  output logic [YW-1:0]          rd_y_o,
  output logic                   rd_en_o,
  input  logic [COLOR_WIDTH-1:0] rd_color_i,
  canvas_scanout_if.master       out_if,
  output logic                   frame_done_o
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN
  } state_e;

  typedef struct packed {
    logic [COLOR_WIDTH-1:0] color;
    logic [XW-1:0]          x;
    logic [YW-1:0]          y;
    logic                   sof;
    logic                   eol;
  } beat_t;

  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  state_e        state_q, state_d;
  logic [XW-1:0] rd_x_q, rd_x_d;
  logic [YW-1:0] rd_y_q, rd_y_d;
  logic          frame_done_q, frame_done_d;

  logic          inflight_q;
  logic [XW-1:0] infl_x_q;
  logic [YW-1:0] infl_y_q;

  beat_t         fifo_q [2];
  logic          rd_ptr_q, wr_ptr_q;
  logic [1:0]    count_q, count_d;

  logic          rd_en;
  logic          push;
  logic          pop;
  logic          last_addr;
  logic [2:0]    occupancy;
  beat_t         head;
  beat_t         push_beat;

  assign push      = inflight_q;
  assign pop       = (count_q != 2'd0) && out_if.out_ready;
  assign last_addr = (rd_x_q == X_LAST) && (rd_y_q == Y_LAST);

  // Slots that will still be occupied after this edge if no read is issued.
  // A pop frees its slot at the same edge, which is what lets a read go out
  // every cycle while the sink keeps out_ready high.
  assign occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};

  assign count_d   = count_q + {1'b0, push} - {1'b0, pop};

  // The beat entering the FIFO takes its coordinates from the read that was
  // issued one edge earlier, not from the live address counter.
  always_comb begin
    push_beat.color = rd_color_i;
    push_beat.x     = infl_x_q;
    push_beat.y     = infl_y_q;
    push_beat.sof   = (infl_x_q == '0) && (infl_y_q == '0);
    push_beat.eol   = (infl_x_q == X_LAST);
  end

  // FSM state register together with the scan datapath registers; reset
  // discards FIFO contents and any read still in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      rd_x_q       <= '0;
      rd_y_q       <= '0;
      frame_done_q <= 1'b0;
      inflight_q   <= 1'b0;
      infl_x_q     <= '0;
      infl_y_q     <= '0;
      count_q      <= 2'd0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_x_q       <= rd_x_d;
      rd_y_q       <= rd_y_d;
      frame_done_q <= frame_done_d;
      inflight_q   <= rd_en;
      count_q      <= count_d;
      if (rd_en) begin
        infl_x_q <= rd_x_q;
        infl_y_q <= rd_y_q;
      end
      if (push) begin
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  // FIFO storage is plain memory; stale entries are never visible because
  // the output is gated by the count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= push_beat;
    end
  end

  // Next-state logic. DRAIN looks at the post-edge FIFO count so that the
  // state is already IDLE (and busy low) in the frame_done cycle, letting a
  // start in that very cycle launch the next frame.
  always_comb begin
    state_d      = state_q;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (rd_en && last_addr) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if ((count_d == 2'd0) && !inflight_q) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Row-major address walk. The counter only moves on an issued read, so a
  // stalled sink freezes rd_x/rd_y at the next address to fetch.
  always_comb begin
    rd_x_d = rd_x_q;
    rd_y_d = rd_y_q;
    if ((state_q == IDLE) && start_i) begin
      rd_x_d = '0;
      rd_y_d = '0;
    end else if (rd_en) begin
      if (rd_x_q == X_LAST) begin
        rd_x_d = '0;
        rd_y_d = (rd_y_q == Y_LAST) ? '0 : rd_y_q + YW'(1);
      end else begin
        rd_x_d = rd_x_q + XW'(1);
      end
    end
  end

  // FSM outputs: issue a read only while the FIFO plus the in-flight read
  // leave room for its data.
  always_comb begin
    busy_o = (state_q != IDLE);
    rd_en  = (state_q == SCAN) && (occupancy < 3'd2);
  end

  assign rd_en_o      = rd_en;
  assign rd_x_o       = rd_x_q;
  assign rd_y_o       = rd_y_q;
  assign frame_done_o = frame_done_q;

  // Stream side presents the FIFO head; every field is blanked while no beat
  // is valid so the sink never sees stale coordinates or markers.
  always_comb begin
    head             = fifo_q[rd_ptr_q];
    out_if.out_valid = (count_q != 2'd0);
    out_if.out_color = COLOR_NONE;
    out_if.out_x     = '0;
    out_if.out_y     = '0;
    out_if.out_sof   = 1'b0;
    out_if.out_eol   = 1'b0;
    if (count_q != 2'd0) begin
      out_if.out_color = head.color;
      out_if.out_x     = head.x;
      out_if.out_y     = head.y;
      out_if.out_sof   = head.sof;
      out_if.out_eol   = head.eol;
    end
  end

endmodule

// File: tb/tb_canvas_scanout.sv
// ---------------------------------------------------------------------------
// tb_canvas_scanout
//
// Bench for canvas_scanout on a 4x2 canvas. A behavioural canvas with a
// one-cycle registered read answers the read port. Expected beats are queued
// when a frame is requested and compared as the stream produces them.
// ---------------------------------------------------------------------------
module tb_canvas_scanout;

  localparam int          W    = 4;
  localparam int          H    = 2;
  localparam int          CW   = 12;
  localparam logic [11:0] NONE = 12'hFFF;

  logic        clk;
  logic        reset;
  logic        start;
  logic        busy;
  logic [1:0]  rd_x;
  logic [0:0]  rd_y;
  logic        rd_en;
  logic [11:0] rd_color;
  logic        frame_done;

  logic [11:0] mem [8];
  logic [16:0] sb [$];

  int  vectors     = 0;
  int  miscompares = 0;
  int  issued      = 0;
  int  accepted    = 0;
  bit  monEn       = 0;

  canvas_scanout_if #(.WIDTH(W), .HEIGHT(H), .COLOR_WIDTH(CW)) sif ();

  canvas_scanout #(
    .WIDTH      (W),
    .HEIGHT     (H),
    .COLOR_WIDTH(CW),
    .COLOR_NONE (NONE)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start_i     (start),
    .busy_o      (busy),
    .rd_x_o      (rd_x),
    .rd_y_o      (rd_y),
    .rd_en_o     (rd_en),
    .rd_color_i  (rd_color),
    .out_if      (sif.master),
    .frame_done_o(frame_done)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural canvas: one-cycle registered read.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_color <= mem[{rd_y, rd_x}];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Request one frame: start high for exactly one sampling edge.
  task automatic applyStimulus();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Expected beats of one frame, layout {sof, eol, y, x, color}.
  task automatic pushFrame(input bit blank);
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        sb.push_back({(x == 0 && y == 0) ? 1'b1 : 1'b0, (x == W - 1) ? 1'b1 : 1'b0,
                      1'(y), 2'(x), blank ? NONE : 12'(x + 4 * y)});
      end
    end
  endtask

  task automatic waitFrameDone(input string tag, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (frame_done) seen = 1;
    end
    checkOutput({tag, "_frame_done"}, 32'(seen), 32'd1);
  endtask

  // Stream monitor: head of the scoreboard must be presented (and held) for
  // as long as out_valid is high; blanked fields otherwise. Reads issued minus
  // beats taken must never exceed two.
  always @(negedge clk) begin
    logic [16:0] beatObs;
    if (monEn) begin
      beatObs = {sif.out_sof, sif.out_eol, sif.out_y, sif.out_x, sif.out_color};
      checkOutput("outstanding_le2", 32'((issued - accepted) <= 2), 32'd1);
      if (sif.out_valid) begin
        checkOutput("sb_has_entry", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          checkOutput("beat", 32'(beatObs), 32'(sb[0]));
          if (sif.out_ready) void'(sb.pop_front());
        end
        if (sif.out_ready) accepted++;
      end else begin
        checkOutput("idle_gating", 32'(beatObs), 32'({5'b0, NONE}));
      end
      if (rd_en) issued++;
    end
  end

  initial begin
    int  baseIssued;
    bit  done;
    int  fdCount;
    logic [7:0] pat;

    for (int i = 0; i < 8; i++) mem[i] = 12'(i);
    reset         = 1'b1;
    start         = 1'b0;
    sif.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state.
    @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_rd_en", 32'(rd_en), 32'd0);
    checkOutput("rst_valid", 32'(sif.out_valid), 32'd0);
    checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
    checkOutput("rst_rd_xy", 32'({rd_y, rd_x}), 32'd0);
    @(posedge clk);
    #1;
    monEn = 1;

    // Full frame with out_ready high: exact latency and back-to-back beats.
    pushFrame(0);
    applyStimulus();
    @(negedge clk);
    checkOutput("full_busy", 32'(busy), 32'd1);
    checkOutput("full_valid_c0", 32'(sif.out_valid), 32'd0);
    @(negedge clk);
    checkOutput("full_valid_c1", 32'(sif.out_valid), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("full_valid_run", 32'(sif.out_valid), 32'd1);
      checkOutput("full_no_done", 32'(frame_done), 32'd0);
    end
    @(negedge clk);
    checkOutput("full_done", 32'(frame_done), 32'd1);
    checkOutput("full_done_busy", 32'(busy), 32'd0);
    checkOutput("full_done_valid", 32'(sif.out_valid), 32'd0);
    @(negedge clk);
    checkOutput("full_done_pulse", 32'(frame_done), 32'd0);
    #1;
    checkOutput("full_sb_empty", 32'(sb.size()), 32'd0);

    // Stall: out_ready low for 10 cycles, only two reads may go out.
    @(posedge clk);
    #1;
    sif.out_ready = 1'b0;
    baseIssued = issued;
    pushFrame(0);
    applyStimulus();
    repeat (10) @(posedge clk);
    #1;
    checkOutput("stall_reads", 32'(issued - baseIssued), 32'd2);
    checkOutput("stall_valid", 32'(sif.out_valid), 32'd1);
    sif.out_ready = 1'b1;
    waitFrameDone("stall", 60);
    #1;
    checkOutput("stall_sb_empty", 32'(sb.size()), 32'd0);

    // Repeating backpressure pattern 1,0,0,1,0,1,1,0.
    @(posedge clk);
    #1;
    pat = 8'b1001_0110;
    pushFrame(0);
    applyStimulus();
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clk);
      #1;
      sif.out_ready = pat[7 - (i % 8)];
      @(negedge clk);
      if (frame_done) done = 1;
    end
    checkOutput("bp_frame_done", 32'(done), 32'd1);
    #1;
    checkOutput("bp_sb_empty", 32'(sb.size()), 32'd0);
    sif.out_ready = 1'b1;

    // Start held high: one frame while busy, relaunch in the frame_done cycle.
    @(posedge clk);
    #1;
    pushFrame(0);
    pushFrame(0);
    start = 1'b1;
    waitFrameDone("restart1", 40);
    checkOutput("restart_done_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    checkOutput("restart_relaunch_busy", 32'(busy), 32'd1);
    waitFrameDone("restart2", 40);
    #1;
    checkOutput("restart_sb_empty", 32'(sb.size()), 32'd0);

    // Reset after the third accepted beat, then a clean frame.
    @(posedge clk);
    #1;
    issued   = 0;
    accepted = 0;
    pushFrame(0);
    applyStimulus();
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk);
      #1;
      if (accepted >= 3) done = 1;
    end
    checkOutput("mid_third_beat", 32'(done), 32'd1);
    monEn = 0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("mid_valid", 32'(sif.out_valid), 32'd0);
    checkOutput("mid_busy", 32'(busy), 32'd0);
    checkOutput("mid_rd_xy", 32'({rd_y, rd_x}), 32'd0);
    checkOutput("mid_rd_en", 32'(rd_en), 32'd0);
    fdCount = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (frame_done) fdCount++;
    end
    checkOutput("mid_no_done", 32'(fdCount), 32'd0);
    @(posedge clk);
    #1;
    sb.delete();
    issued   = 0;
    accepted = 0;
    monEn    = 1;
    pushFrame(0);
    applyStimulus();
    waitFrameDone("post_reset", 40);
    #1;
    checkOutput("post_reset_sb_empty", 32'(sb.size()), 32'd0);

    // Blank canvas: every beat carries the blank colour.
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) mem[i] = NONE;
    pushFrame(1);
    applyStimulus();
    waitFrameDone("blank", 40);
    #1;
    checkOutput("blank_sb_empty", 32'(sb.size()), 32'd0);

    @(posedge clk);
    #1;
    monEn = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
